trig_seq_monitor: RTL and testbench

- Runtime trust monitor that sits beside the AES core on the plaintext input bus.
- Matches each valid input word against a programmable, masked table of NUM_PAT patterns.
- Raises a sticky alarm when all NUM_PAT patterns arrive in order within WINDOW valid samples.
- Generalises the fixed single-pattern trigger detector to parametrised data width, sequence depth, window and maskable compare, for Trojan-activation detection during test.

---
 rtl/trig_seq_monitor.sv | 136 +++++++++++++
 tb/tb_trig_seq_monitor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : trig_seq_monitor
//  Purpose  : Masked multi-pattern sequence detector on a monitored data bus;
//             raises a sticky alarm when NUM_PAT patterns arrive in order
//             within WINDOW valid samples.
//  Revision : 1.0  initial release
// ============================================================================
module trig_seq_monitor #(
    parameter int DATA_W  = 128,
    parameter int NUM_PAT = 4,
    parameter int WINDOW  = 1024,
    parameter int CNT_W   = 16,
    localparam int AW     = ($clog2(NUM_PAT) < 1) ? 1 : $clog2(NUM_PAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_pat,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              alarm_clr,
    output logic              alarm,
    output logic [CNT_W-1:0]  alarm_count,
    output logic [AW:0]       stage,
    output logic              busy
);

    localparam int WIN_W               = ($clog2(WINDOW + 1) < 2) ? 2 : $clog2(WINDOW + 1);
    localparam int LAST_I              = NUM_PAT - 1;
    localparam logic [AW:0] LAST_STAGE = LAST_I[AW:0];
    localparam logic [AW:0] STAGE_IDLE = {(AW + 1){1'b0}};
    localparam logic [AW:0] STAGE_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [WIN_W:0] WIN_LIMIT  = WINDOW[WIN_W:0];
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W - 1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] pat_tbl  [NUM_PAT];
    logic [DATA_W-1:0] mask_tbl [NUM_PAT];
    logic [NUM_PAT-1:0] pat_hit;

    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_cnt_n;
    logic [WIN_W:0]   win_inc;
    logic [AW:0]      stage_n;
    logic             detect;
    logic             match_cur;
    logic             addr_ok;
    logic             tbl_we;

    assign addr_ok = ({{(32 - AW){1'b0}}, cfg_addr} < 32'(NUM_PAT));
    assign tbl_we  = cfg_we && !arm && addr_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_PAT; k++) begin
                pat_tbl[k]  <= '0;
                mask_tbl[k] <= '0;
            end
        end else if (tbl_we) begin
            pat_tbl[cfg_addr]  <= cfg_pat;
            mask_tbl[cfg_addr] <= cfg_mask;
        end
    end

    // A cleared mask bit is a don't-care, so an all-zero mask matches anything.
    for (genvar k = 0; k < NUM_PAT; k++) begin : g_match
        assign pat_hit[k] = ((in_data ^ pat_tbl[k]) & mask_tbl[k]) == '0;
    end

    assign match_cur = pat_hit[stage[AW-1:0]];
    assign win_inc   = {1'b0, win_cnt} + {{WIN_W{1'b0}}, 1'b1};

    always_comb begin
        stage_n   = stage;
        win_cnt_n = win_cnt;
        detect    = 1'b0;
        if (!arm) begin
            stage_n   = STAGE_IDLE;
            win_cnt_n = '0;
        end else if (in_valid) begin
            if (stage == STAGE_IDLE) begin
                if (pat_hit[0]) begin
                    stage_n   = STAGE_ONE;
                    win_cnt_n = WIN_ONE;
                end
            end else if (win_inc > WIN_LIMIT) begin
                // Window exhausted: abandon the partial sequence outright.
                stage_n   = STAGE_IDLE;
                win_cnt_n = '0;
            end else if (match_cur) begin
                if (stage == LAST_STAGE) begin
                    detect    = 1'b1;
                    stage_n   = STAGE_IDLE;
                    win_cnt_n = '0;
                end else begin
                    stage_n   = stage + 1'b1;
                    win_cnt_n = win_inc[WIN_W-1:0];
                end
            end else if (pat_hit[0]) begin
                stage_n   = STAGE_ONE;
                win_cnt_n = WIN_ONE;
            end else begin
                stage_n   = STAGE_IDLE;
                win_cnt_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage       <= STAGE_IDLE;
            win_cnt     <= '0;
            busy        <= 1'b0;
            alarm       <= 1'b0;
            alarm_count <= '0;
        end else begin
            stage   <= stage_n;
            win_cnt <= win_cnt_n;
            busy    <= (stage_n != STAGE_IDLE);
            // Detection outranks a simultaneous clear request.
            if (detect) begin
                alarm <= 1'b1;
            end else if (alarm_clr) begin
                alarm <= 1'b0;
            end
            if (detect && !(&alarm_count)) begin
                alarm_count <= alarm_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trig_seq_monitor.sv
`default_nettype none
// Bench for trig_seq_monitor: vector table, directed corner sequences and a
// randomized run checked against a sample-index based reference model.
module tb_trig_seq_monitor;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = '0;
    logic [DW-1:0] cfg_pat = '0;
    logic [DW-1:0] cfg_mask = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          alarm_clr = 1'b0;

    logic        alarm, busy;
    logic [15:0] alarm_count;
    logic [2:0]  stage;
    logic        a3, b3, a4, b4;
    logic [15:0] c3;
    logic [1:0]  c4;
    logic [2:0]  s3, s4;

    trig_seq_monitor #(.DATA_W(DW), .NUM_PAT(4), .WINDOW(1024), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .arm(arm), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .in_valid(in_valid), .in_data(in_data),
        .alarm_clr(alarm_clr), .alarm(alarm), .alarm_count(alarm_count),
        .stage(stage), .busy(busy));

    trig_seq_monitor #(.DATA_W(DW), .NUM_PAT(4), .WINDOW(3), .CNT_W(16)) u_w3 (
        .clk(clk), .rst(rst), .arm(arm), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .in_valid(in_valid), .in_data(in_data),
        .alarm_clr(alarm_clr), .alarm(a3), .alarm_count(c3), .stage(s3), .busy(b3));

    trig_seq_monitor #(.DATA_W(DW), .NUM_PAT(4), .WINDOW(4), .CNT_W(2)) u_w4 (
        .clk(clk), .rst(rst), .arm(arm), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .in_valid(in_valid), .in_data(in_data),
        .alarm_clr(alarm_clr), .alarm(a4), .alarm_count(c4), .stage(s4), .busy(b4));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] P0, P1, P2, P3, XW, ONES;

    typedef struct {
        bit            valid;
        logic [DW-1:0] data;
        bit            clr;
        int            st;
        bit            al;
        int            cnt;
    } vec_t;
    vec_t vecs[$];

    // Reference model state: progress, sample index of first match, sample count
    logic [DW-1:0] m_pat[4];
    logic [DW-1:0] m_mask[4];
    int m_prog, m_start, m_n, m_count;
    bit m_alarm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic add(input bit v, input logic [DW-1:0] d, input bit c,
                       input int st, input bit al, input int cnt);
        vec_t r;
        r.valid = v; r.data = d; r.clr = c; r.st = st; r.al = al; r.cnt = cnt;
        vecs.push_back(r);
    endtask

    task automatic load(input int a, input logic [DW-1:0] p, input logic [DW-1:0] m);
        arm = 1'b0; in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = a[1:0]; cfg_pat = p; cfg_mask = m;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic drive(input logic [DW-1:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic bit m_match(input int k, input logic [DW-1:0] d);
        return ((d ^ m_pat[k]) & m_mask[k]) == '0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_pat[k] = '0; m_mask[k] = '0;
        end
        m_prog = 0; m_start = 0; m_n = 0; m_count = 0; m_alarm = 1'b0;
    endtask

    task automatic model_apply(input bit a, input bit v, input bit we, input int addr,
                               input logic [DW-1:0] p, input logic [DW-1:0] m,
                               input bit c, input logic [DW-1:0] d);
        bit det;
        det = 1'b0;
        if (!a) begin
            m_prog = 0;
            if (we) begin
                m_pat[addr] = p; m_mask[addr] = m;
            end
        end else if (v) begin
            m_n++;
            if (m_prog == 0) begin
                if (m_match(0, d)) begin m_prog = 1; m_start = m_n; end
            end else if (m_n - m_start + 1 > 1024) begin
                m_prog = 0;
            end else if (m_match(m_prog, d)) begin
                m_prog++;
                if (m_prog == 4) begin det = 1'b1; m_prog = 0; end
            end else if (m_match(0, d)) begin
                m_prog = 1; m_start = m_n;
            end else begin
                m_prog = 0;
            end
        end
        if (det) begin
            m_alarm = 1'b1;
            if (m_count < 65535) m_count++;
        end else if (c) begin
            m_alarm = 1'b0;
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        P0 = {16{8'h11}}; P1 = {16{8'h22}}; P2 = {16{8'h33}}; P3 = {16{8'h44}};
        XW = {16{8'hA5}}; ONES = '1;

        add(1, P0, 0, 1, 0, 0); add(1, P1, 0, 2, 0, 0); add(0, XW, 0, 2, 0, 0);
        add(1, P2, 0, 3, 0, 0); add(1, P3, 0, 0, 1, 1); add(0, XW, 1, 0, 0, 1);
        add(1, P0, 0, 1, 0, 1); add(1, P1, 0, 2, 0, 1); add(1, P0, 0, 1, 0, 1);
        add(1, P1, 0, 2, 0, 1); add(1, P2, 0, 3, 0, 1); add(1, P3, 0, 0, 1, 2);
        add(1, P0, 0, 1, 1, 2); add(1, XW, 0, 0, 1, 2); add(1, P1, 0, 0, 1, 2);
        add(1, P0, 0, 1, 1, 2); add(1, P2, 0, 0, 1, 2); add(1, P0, 0, 1, 1, 2);
        add(1, P1, 0, 2, 1, 2); add(1, P2, 0, 3, 1, 2); add(1, P3, 1, 0, 1, 3);
        add(0, XW, 1, 0, 0, 3); add(1, P0, 0, 1, 0, 3); add(1, P1, 0, 2, 0, 3);
        add(1, P2, 0, 3, 0, 3); add(1, P0, 0, 1, 0, 3);

        #12;
        chk("reset_alarm", 32'(alarm), 0);
        chk("reset_count", 32'(alarm_count), 0);
        chk("reset_stage", 32'(stage), 0);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b1;
        tick();

        load(0, P0, ONES); load(1, P1, ONES); load(2, P2, ONES); load(3, P3, ONES);
        arm = 1'b1;

        foreach (vecs[i]) begin
            in_valid = vecs[i].valid; in_data = vecs[i].data; alarm_clr = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_stage", i), 32'(stage), 32'(vecs[i].st));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].st != 0));
            chk($sformatf("vec%0d_alarm", i), 32'(alarm), 32'(vecs[i].al));
            chk($sformatf("vec%0d_count", i), 32'(alarm_count), 32'(vecs[i].cnt));
        end
        in_valid = 1'b0; alarm_clr = 1'b0;
        arm = 1'b0; tick(); arm = 1'b1;

        // Window boundary: WINDOW=3 aborts on the 4th word, WINDOW=4 detects.
        drive(P0); drive(P1); drive(P2);
        chk("w3_stage_before_last", 32'(s3), 3);
        drive(P3);
        chk("w3_no_alarm", 32'(a3), 0);
        chk("w3_stage_reset", 32'(s3), 0);
        chk("w3_count", 32'(c3), 0);
        chk("w4_alarm_exact", 32'(a4), 1);
        chk("w4_count_saturated", 32'(c4), 3);
        chk("main_count_window", 32'(alarm_count), 4);

        // Masked compare on pattern 2: only the low byte is compared.
        alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
        load(2, P2, 128'hFF); arm = 1'b1;
        d = rand128(); d[7:0] = 8'h33;
        drive(P0); drive(P1); drive(d); drive(P3);
        chk("mask_detect_alarm", 32'(alarm), 1);
        chk("mask_detect_count", 32'(alarm_count), 5);

        // arm drop mid-sequence clears progress but keeps alarm state.
        drive(P0); drive(P1);
        chk("arm_pre_stage", 32'(stage), 2);
        arm = 1'b0; tick(); arm = 1'b1;
        chk("arm_drop_stage", 32'(stage), 0);
        chk("arm_drop_busy", 32'(busy), 0);
        chk("arm_drop_alarm", 32'(alarm), 1);
        chk("arm_drop_count", 32'(alarm_count), 5);

        alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
        chk("clr_alone_alarm", 32'(alarm), 0);
        chk("clr_alone_count", 32'(alarm_count), 5);
        d = rand128(); d[7:0] = 8'h32;
        drive(P0); drive(P1); drive(d);
        chk("mask_flip_stage", 32'(stage), 0);
        drive(P3);
        chk("mask_flip_alarm", 32'(alarm), 0);
        chk("mask_flip_count", 32'(alarm_count), 5);

        // Table write while armed must be ignored.
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_pat = XW; cfg_mask = ONES;
        tick(); cfg_we = 1'b0;
        drive(XW);
        chk("armed_write_ignored_x", 32'(stage), 0);
        drive(P0); drive(P1); drive(P2); drive(P3);
        chk("armed_write_detect", 32'(alarm_count), 6);

        // Asynchronous reset mid-sequence.
        drive(P0); drive(P1);
        chk("rst_pre_stage", 32'(stage), 2);
        #3 rst = 1'b0;
        #1;
        chk("rst_async_stage", 32'(stage), 0);
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_alarm", 32'(alarm), 0);
        chk("rst_async_count", 32'(alarm_count), 0);
        #2 rst = 1'b1;
        // Cleared table has zero masks, so arbitrary words now match every stage.
        drive(XW);
        chk("rst_tbl_stage1", 32'(stage), 1);
        drive(XW); drive(XW);
        chk("rst_tbl_stage3", 32'(stage), 3);
        drive(XW);
        chk("rst_tbl_alarm", 32'(alarm), 1);
        chk("rst_tbl_count", 32'(alarm_count), 1);

        // Randomized run against the reference model from a fresh reset.
        #3 rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        arm = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int k;
            if ($urandom_range(0, 39) == 0) arm = ~arm;
            cfg_we = ($urandom_range(0, 2) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       cfg_mask = '0;
                1, 2:    cfg_mask = 128'hFF;
                default: cfg_mask = ONES;
            endcase
            cfg_pat = rand128();
            in_valid = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 8)
                in_data = (m_pat[k] & m_mask[k]) | (rand128() & ~m_mask[k]);
            else
                in_data = rand128();
            alarm_clr = ($urandom_range(0, 9) == 0);
            model_apply(arm, in_valid, cfg_we, int'(cfg_addr), cfg_pat, cfg_mask,
                        alarm_clr, in_data);
            tick();
            chk("rnd_stage", 32'(stage), 32'(m_prog));
            chk("rnd_busy", 32'(busy), 32'(m_prog != 0));
            chk("rnd_alarm", 32'(alarm), 32'(m_alarm));
            chk("rnd_count", 32'(alarm_count), 32'(m_count));
            chk("rnd_count_sat2", 32'(c4), 32'((m_count > 3) ? 3 : m_count));
        end
        cfg_we = 1'b0; in_valid = 1'b0; alarm_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
